wave_gen: RTL and testbench
===========================

Name: wave_gen

Overview:
- Dual-channel direct-digital-synthesis sample source that produces the signed 12-bit dac_a / dac_b words consumed by the SPI DAC driver stage.
- Per channel: 32-bit phase accumulator, waveform shaper (DC, sine, sawtooth, triangle, square), amplitude scale, offset add and saturation.
- Advances one sample per sample_en strobe, which the DAC frame timing supplies.
- Outputs hold between strobes, so the SPI stage can read them at any time.

Parameters:
- PHASE_W, 32, phase accumulator and tuning word width.
- LUT_AW, 10, sine ROM address bits (full-wave table, 2^LUT_AW entries).
- DATA_W, 12, signed sample width.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- sample_en  in  1  one-cycle strobe; compute the next sample for both channels.
- phase_clr  in  1  one-cycle strobe; zero both accumulators (channel alignment).
- mode_a, mode_b  in  3  waveform select: 0 DC, 1 sine, 2 saw, 3 triangle, 4 square, 5-7 treated as DC.
- ftw_a, ftw_b  in  PHASE_W  frequency tuning word, added per sample.
- amp_a, amp_b  in  13  unsigned gain, 4096 = unity; values >4096 clamp to 4096.
- offset_a, offset_b  in  DATA_W  signed offset.
- duty_a, duty_b  in  8  square duty threshold.
- dac_a, dac_b  out  DATA_W  signed sample to the SPI stage.
- sample_valid  out  1  one-cycle pulse when dac_a/dac_b update.

Behaviour:
- Reset (rst_n=0 at posedge): phase_a = phase_b = 0; all pipeline valid bits 0; dac_a = dac_b = 0; sample_valid = 0. Reset asserted mid-operation flushes in-flight samples; no sample_valid is emitted for them.
- Stage 0 (sample_en cycle):
  - Latch the current phase p plus mode, amp, offset and duty per channel.
  - Accumulator becomes p + ftw, mod 2^PHASE_W (wraps silently).
  - Control inputs are sampled only in this cycle.
- phase_clr without sample_en: both accumulators go to 0.
- phase_clr with sample_en in the same cycle: the sample uses p = 0 and the accumulator loads ftw.
- Stage 1 (registered waveform w, signed 12-bit), with u = top 13 bits of p:
  - DC: w = 0.
  - Sine: w = ROM[p top LUT_AW bits], ROM[k] = round(2047*sin(2*pi*k/2^LUT_AW)).
  - Saw: w = p[top 12] - 2048, giving -2048..2047.
  - Triangle: u<4096 gives w = u-2048; otherwise w = 6143-u. Points: u=0 gives -2048, u=4095/4096 give 2047, u=8191 gives -2048.
  - Square: w = +2047 if p[top 8] < duty, else -2047. duty=0 gives constant -2047.
- Stage 2: product = w * amp_clamped (signed 12 x unsigned 13, 25-bit signed); scaled = product >>> 12 (arithmetic shift, floor).
- Stage 3: sum = scaled + offset computed in 14 bits, saturated to -2048..2047. Saturation result is registered into dac_x, and sample_valid pulses.
- Latency: sample_valid is high exactly 3 cycles after the sample_en cycle.
- Fully pipelined: sample_en may assert on consecutive cycles; each strobe yields one valid pulse.
- Both channels share timing and update in the same cycle.

Decomposition:
- Package wave_gen_pkg:
  - mode enum: WAVE_DC, WAVE_SINE, WAVE_SAW, WAVE_TRI, WAVE_SQR.
  - Constants: SAMPLE_MAX = 2047, SAMPLE_MIN = -2048, AMP_UNITY = 4096, PIPE_LAT = 3.
- Sub-module sine_rom:
  - Synchronous read, 1-cycle, initialised from generated table.
  - Instantiated once per channel; alternatively one dual-port instance.

Test Plan:
- Reset: rst_n low 2 cycles, then high, no strobes -> dac_a = dac_b = 0, sample_valid never asserts.
- Saw ramp:
  - Setup: mode_a=2, ftw_a=0x0010_0000, amp_a=4096, offset_a=0, one sample_en every 8 cycles.
  - Expected: dac_a = -2048, -2047, -2046, ...; sample_valid exactly 3 cycles after each strobe.
  - Wrap: after 4096 samples dac_a returns from 2047 to -2048.
- Triangle plus saturation:
  - Setup: mode_b=3, phase driven to u=4095, amp_b=4096, offset_b=100.
  - Expected: dac_b = 2047 (saturated). With offset_b=-100, dac_b = 1947.
- Sine and gain:
  - Setup: mode_a=1, ftw_a=2^30 (quarter-turn steps), amp_a=2048.
  - Expected: dac_a sequence 0, 1023, 0, -1024, repeating (floor of 2047/2 and -2047/2).
  - amp_a=5000 -> same as amp_a=4096: 0, 2047, 0, -2047.
- Square duty:
  - Setup: mode_a=4, duty_a=64, ftw_a=2^24.
  - Expected: 64 samples of 2047 then 192 of -2047 per period. duty_a=0 -> all -2047.
- Strobe collisions:
  - phase_clr with sample_en (ftw=0x100) -> that sample uses phase 0; next sample uses phase 0x100.
  - sample_en on 3 consecutive cycles -> 3 consecutive sample_valid pulses.
  - rst_n low 1 cycle after a strobe -> no sample_valid pulse.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the dual-channel DDS sample source.
package wave_gen_pkg;

  typedef enum logic [2:0] {
    WAVE_DC   = 3'd0,
    WAVE_SINE = 3'd1,
    WAVE_SAW  = 3'd2,
    WAVE_TRI  = 3'd3,
    WAVE_SQR  = 3'd4
  } wave_mode_e;

  localparam int SAMPLE_MAX = 2047;
  localparam int SAMPLE_MIN = -2048;
  localparam int AMP_UNITY  = 4096;
  localparam int AMP_SHIFT  = 12;
  localparam int PIPE_LAT   = 3;

  // Gains above unity are clamped so the shaper never exceeds full scale.
  function automatic logic [12:0] clamp_amp(input logic [12:0] a);
    if (a > 13'(AMP_UNITY)) return 13'(AMP_UNITY);
    return a;
  endfunction

endpackage

// File: rtl/wave_gen_sine_rom.sv
// Full-wave sine table, ROM[k] = round((2^(DW-1)-1) * sin(2*pi*k/2^AW)), one-cycle synchronous read.
module wave_gen_sine_rom #(
  parameter int AW = 10,
  parameter int DW = 12
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [AW-1:0]        addr,
  output logic signed [DW-1:0] data
);

  localparam int N    = 2 ** AW;
  localparam int FULL = 2 ** (DW - 1) - 1;

  // Table contents are elaboration constants: quarter-wave folding plus a Taylor series.
  function automatic logic signed [DW-1:0] sine_entry(input int k);
    int  q;
    int  r;
    bit  neg;
    real x;
    real s;
    real t;
    q   = k % (N / 2);
    neg = (k >= N / 2);
    if (q > N / 4) q = N / 2 - q;
    x = 2.0 * 3.14159265358979323846 * $itor(q) / $itor(N);
    s = 0.0;
    t = x;
    for (int n = 0; n < 12; n++) begin
      s = s + t;
      t = -t * x * x / $itor((2 * n + 2) * (2 * n + 3));
    end
    r = $rtoi($itor(FULL) * s + 0.5);
    return DW'(neg ? -r : r);
  endfunction

  logic signed [DW-1:0] table_q [N];

  for (genvar k = 0; k < N; k++) begin : g_tab
    assign table_q[k] = sine_entry(k);
  end

  always_ff @(posedge clk) begin
    if (en) data <= table_q[addr];
  end

endmodule

// File: rtl/wave_gen.sv
// Dual-channel DDS: phase accumulator, waveform shaper, gain, offset and saturation per channel.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int DATA_W  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic               phase_clr,
  input  logic [2:0]         mode_a,
  input  logic [2:0]         mode_b,
  input  logic [PHASE_W-1:0] ftw_a,
  input  logic [PHASE_W-1:0] ftw_b,
  input  logic [12:0]        amp_a,
  input  logic [12:0]        amp_b,
  input  logic [DATA_W-1:0]  offset_a,
  input  logic [DATA_W-1:0]  offset_b,
  input  logic [7:0]         duty_a,
  input  logic [7:0]         duty_b,
  output logic [DATA_W-1:0]  dac_a,
  output logic [DATA_W-1:0]  dac_b,
  output logic               sample_valid
);

  // Handshake: sample_en is a one-cycle request with no backpressure; sample_valid pulses
  // for one cycle exactly PIPE_LAT cycles later, and dac_a/dac_b hold between pulses.
  localparam int NCH   = 2;
  localparam int AMP_W = 13;
  localparam int U_W   = DATA_W + 1;
  localparam int HALF  = 2 ** (DATA_W - 1);
  localparam int PW    = DATA_W + AMP_W + 1;

  logic [2:0]               mode_in [NCH];
  logic [PHASE_W-1:0]       ftw_in  [NCH];
  logic [AMP_W-1:0]         amp_in  [NCH];
  logic signed [DATA_W-1:0] off_in  [NCH];
  logic [7:0]               duty_in [NCH];

  assign mode_in[0] = mode_a;   assign mode_in[1] = mode_b;
  assign ftw_in[0]  = ftw_a;    assign ftw_in[1]  = ftw_b;
  assign amp_in[0]  = amp_a;    assign amp_in[1]  = amp_b;
  assign off_in[0]  = offset_a; assign off_in[1]  = offset_b;
  assign duty_in[0] = duty_a;   assign duty_in[1] = duty_b;

  logic [PHASE_W-1:0]       phase    [NCH];
  logic [PHASE_W-1:0]       p_eff    [NCH];
  logic [LUT_AW-1:0]        rom_addr [NCH];
  logic signed [DATA_W-1:0] rom_q    [NCH];
  logic signed [DATA_W-1:0] w_next   [NCH];

  logic [2:0]               mode1 [NCH];
  logic signed [DATA_W-1:0] w1    [NCH];
  logic [AMP_W-1:0]         amp1  [NCH];
  logic signed [DATA_W-1:0] off1  [NCH];
  logic                     valid1;

  logic signed [DATA_W-1:0] wsel        [NCH];
  logic signed [PW-1:0]     prod        [NCH];
  logic signed [DATA_W:0]   scaled_next [NCH];
  logic signed [DATA_W:0]   scaled2     [NCH];
  logic signed [DATA_W-1:0] off2        [NCH];
  logic                     valid2;

  logic signed [DATA_W+1:0] sum     [NCH];
  logic signed [DATA_W-1:0] sat_next[NCH];
  logic [DATA_W-1:0]        dac_q   [NCH];

  assign dac_a = dac_q[0];
  assign dac_b = dac_q[1];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // A simultaneous phase_clr makes this strobe's sample start from phase 0.
    assign p_eff[c]    = phase_clr ? '0 : phase[c];
    assign rom_addr[c] = p_eff[c][PHASE_W-1 -: LUT_AW];

    wave_gen_sine_rom #(.AW(LUT_AW), .DW(DATA_W)) u_rom (
      .clk  (clk),
      .en   (sample_en),
      .addr (rom_addr[c]),
      .data (rom_q[c])
    );
  end

  // Stage 1 shaper for the arithmetic waveforms; sine comes from the ROM register.
  always_comb begin
    logic [U_W-1:0] u;
    u = '0;
    for (int c = 0; c < NCH; c++) begin
      u = p_eff[c][PHASE_W-1 -: U_W];
      case (mode_in[c])
        WAVE_SAW: w_next[c] = p_eff[c][PHASE_W-1 -: DATA_W] - DATA_W'(HALF);
        WAVE_TRI: w_next[c] = u[U_W-1] ? DATA_W'(U_W'(3 * HALF - 1) - u)
                                       : DATA_W'(u - U_W'(HALF));
        WAVE_SQR: w_next[c] = (p_eff[c][PHASE_W-1 -: 8] < duty_in[c]) ? DATA_W'(SAMPLE_MAX)
                                                                       : DATA_W'(-SAMPLE_MAX);
        default:  w_next[c] = '0;
      endcase
    end
  end

  // Stage 2 gain: floor division by unity via arithmetic shift.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wsel[c]        = (mode1[c] == WAVE_SINE) ? rom_q[c] : w1[c];
      prod[c]        = wsel[c] * $signed({1'b0, amp1[c]});
      scaled_next[c] = (DATA_W + 1)'(prod[c] >>> AMP_SHIFT);
    end
  end

  // Stage 3 offset and saturation.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sum[c] = (DATA_W + 2)'(scaled2[c]) + (DATA_W + 2)'(off2[c]);
      if (sum[c] > (DATA_W + 2)'(SAMPLE_MAX))
        sat_next[c] = DATA_W'(SAMPLE_MAX);
      else if (sum[c] < (DATA_W + 2)'(SAMPLE_MIN))
        sat_next[c] = DATA_W'(SAMPLE_MIN);
      else
        sat_next[c] = sum[c][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid1       <= 1'b0;
      valid2       <= 1'b0;
      sample_valid <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        phase[c]   <= '0;
        mode1[c]   <= '0;
        w1[c]      <= '0;
        amp1[c]    <= '0;
        off1[c]    <= '0;
        scaled2[c] <= '0;
        off2[c]    <= '0;
        dac_q[c]   <= '0;
      end
    end else begin
      valid1       <= sample_en;
      valid2       <= valid1;
      sample_valid <= valid2;
      for (int c = 0; c < NCH; c++) begin
        if (sample_en) begin
          phase[c] <= p_eff[c] + ftw_in[c];
          mode1[c] <= mode_in[c];
          w1[c]    <= w_next[c];
          amp1[c]  <= clamp_amp(amp_in[c]);
          off1[c]  <= off_in[c];
        end else if (phase_clr) begin
          phase[c] <= '0;
        end
        if (valid1) begin
          scaled2[c] <= scaled_next[c];
          off2[c]    <= off1[c];
        end
        if (valid2) dac_q[c] <= sat_next[c];
      end
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Bench for wave_gen: constant vector table, hand sequences and random strobes against a spec model.
module tb_wave_gen;
  import wave_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, sample_en, phase_clr;
  logic [2:0]  mode_a, mode_b;
  logic [31:0] ftw_a, ftw_b;
  logic [12:0] amp_a, amp_b;
  logic [11:0] offset_a, offset_b;
  logic [7:0]  duty_a, duty_b;
  logic [11:0] dac_a, dac_b;
  logic        sample_valid;

  wave_gen dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .phase_clr(phase_clr),
    .mode_a(mode_a), .mode_b(mode_b), .ftw_a(ftw_a), .ftw_b(ftw_b),
    .amp_a(amp_a), .amp_b(amp_b), .offset_a(offset_a), .offset_b(offset_b),
    .duty_a(duty_a), .duty_b(duty_b), .dac_a(dac_a), .dac_b(dac_b),
    .sample_valid(sample_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [11:0] exp_q_a[$];
  logic [11:0] exp_q_b[$];
  int          exp_t_q[$];
  logic [11:0] got_a[$];
  logic [11:0] got_b[$];
  logic [11:0] last_a, last_b;
  int          n_valid = 0;
  logic [31:0] ph_a, ph_b;

  function automatic int s12(input logic [11:0] x);
    return int'($signed(x));
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sine_ref(input int k);
    real v;
    v = 2047.0 * $sin(2.0 * 3.14159265358979 * $itor(k) / 1024.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int model_sample(input logic [2:0] mode, input logic [31:0] p,
                                      input logic [12:0] amp, input logic [11:0] off,
                                      input logic [7:0] duty);
    int w, u, ampc, prod, sc, s;
    u = int'(p >> 19);
    case (mode)
      3'd1:    w = sine_ref(int'(p >> 22));
      3'd2:    w = int'(p >> 20) - 2048;
      3'd3:    w = (u < 4096) ? u - 2048 : 6143 - u;
      3'd4:    w = (int'(p >> 24) < int'(duty)) ? 2047 : -2047;
      default: w = 0;
    endcase
    ampc = (int'(amp) > 4096) ? 4096 : int'(amp);
    prod = w * ampc;
    if (prod >= 0) sc = prod / 4096;
    else           sc = -((-prod + 4095) / 4096);
    s = sc + s12(off);
    if (s > 2047)  s = 2047;
    if (s < -2048) s = -2048;
    return s;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sample_valid) begin
        int want;
        n_valid++;
        got_a.push_back(dac_a);
        got_b.push_back(dac_b);
        want = (exp_t_q.size() > 0) ? exp_t_q[0] : -1;
        check("valid_cycle", cyc, want);
        if (want == cyc) begin
          void'(exp_t_q.pop_front());
          last_a = exp_q_a.pop_front();
          last_b = exp_q_b.pop_front();
          check("dac_a", s12(dac_a), s12(last_a));
          check("dac_b", s12(dac_b), s12(last_b));
        end
      end else if (exp_t_q.size() > 0 && exp_t_q[0] <= cyc) begin
        check("sample_valid", int'(sample_valid), 1);
        void'(exp_t_q.pop_front());
        void'(exp_q_a.pop_front());
        void'(exp_q_b.pop_front());
      end else begin
        check("hold_a", s12(dac_a), s12(last_a));
        check("hold_b", s12(dac_b), s12(last_b));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; sample_en = 1'b0; phase_clr = 1'b0;
    exp_q_a.delete(); exp_q_b.delete(); exp_t_q.delete();
    ph_a = '0; ph_b = '0; last_a = '0; last_b = '0;
    idle(n);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit en, input bit clr);
    logic [31:0] pa, pb;
    sample_en = en;
    phase_clr = clr;
    if (en) begin
      pa = clr ? 32'd0 : ph_a;
      pb = clr ? 32'd0 : ph_b;
      exp_q_a.push_back(12'(model_sample(mode_a, pa, amp_a, offset_a, duty_a)));
      exp_q_b.push_back(12'(model_sample(mode_b, pb, amp_b, offset_b, duty_b)));
      exp_t_q.push_back(cyc + PIPE_LAT);
      ph_a = pa + ftw_a;
      ph_b = pb + ftw_b;
    end else if (clr) begin
      ph_a = '0;
      ph_b = '0;
    end
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    phase_clr = 1'b0;
  endtask

  task automatic set_both(input logic [2:0] m, input logic [12:0] a, input logic [11:0] o,
                          input logic [7:0] d);
    mode_a = m; amp_a = a; offset_a = o; duty_a = d;
    mode_b = m; amp_b = a; offset_b = o; duty_b = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] phase;
    logic [12:0] amp;
    logic [11:0] off;
    logic [7:0]  duty;
    logic [11:0] expv;
  } vec_t;

  function automatic vec_t mk(input int m, input logic [31:0] ph, input int a, input int o,
                              input int d, input int e);
    vec_t v;
    v.mode = 3'(m); v.phase = ph; v.amp = 13'(a); v.off = 12'(o); v.duty = 8'(d);
    v.expv = 12'(e);
    return v;
  endfunction

  vec_t vecs [18];
  int   sine_exp [4];
  int   cnt, snap;

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; phase_clr = 1'b0;
    set_both(3'd0, 13'd4096, 12'd0, 8'd0);
    ftw_a = '0; ftw_b = '0;
    last_a = '0; last_b = '0; ph_a = '0; ph_b = '0;

    vecs[0]  = mk(3, 32'h7FF8_0000, 4096,  100,  0,  2047);
    vecs[1]  = mk(3, 32'h7FF8_0000, 4096, -100,  0,  1947);
    vecs[2]  = mk(3, 32'h8000_0000, 4096,    0,  0,  2047);
    vecs[3]  = mk(3, 32'hFFF8_0000, 4096, -100,  0, -2048);
    vecs[4]  = mk(3, 32'h0000_0000, 4096,    0,  0, -2048);
    vecs[5]  = mk(2, 32'h8000_0000, 4096,    5,  0,     5);
    vecs[6]  = mk(1, 32'h4000_0000, 2048,    0,  0,  1023);
    vecs[7]  = mk(1, 32'hC000_0000, 2048,    0,  0, -1024);
    vecs[8]  = mk(1, 32'h4000_0000, 5000,    0,  0,  2047);
    vecs[9]  = mk(4, 32'h3F00_0000, 4096,    0, 64,  2047);
    vecs[10] = mk(4, 32'h4000_0000, 4096,    0, 64, -2047);
    vecs[11] = mk(4, 32'h0000_0000, 4096,    0,  0, -2047);
    vecs[12] = mk(0, 32'h1234_5678, 4096, -300,  0,  -300);
    vecs[13] = mk(7, 32'h0000_0000, 4096, 1000,  0,  1000);
    vecs[14] = mk(2, 32'h0000_0000,    0,    0,  0,     0);
    vecs[15] = mk(2, 32'h0000_0000, 4096,   -1,  0, -2048);
    vecs[16] = mk(2, 32'hFFF0_0000,    1,    0,  0,     0);
    vecs[17] = mk(2, 32'h0000_0000,    1,    0,  0,    -1);

    idle(1);
    do_reset(2);

    // Reset state: no strobes, outputs zero and no valid pulse.
    idle(8);
    check("reset_dac_a", s12(dac_a), 0);
    check("reset_dac_b", s12(dac_b), 0);
    check("reset_no_valid", n_valid, 0);

    // Table vectors: load phase via clear+strobe, then sample at that phase.
    for (int i = 0; i < 18; i++) begin
      set_both(vecs[i].mode, vecs[i].amp, vecs[i].off, vecs[i].duty);
      ftw_a = vecs[i].phase; ftw_b = vecs[i].phase;
      step(1'b1, 1'b1);
      ftw_a = '0; ftw_b = '0;
      step(1'b1, 1'b0);
      idle(4);
      check($sformatf("vec%0d_a", i), s12(dac_a), s12(vecs[i].expv));
      check($sformatf("vec%0d_b", i), s12(dac_b), s12(vecs[i].expv));
    end

    // Saw ramp over a full period, one strobe every 8 cycles.
    set_both(3'd0, 13'd4096, 12'd0, 8'd0);
    mode_a = 3'd2; ftw_a = 32'h0010_0000; ftw_b = 32'h0;
    step(1'b0, 1'b1);
    idle(4);
    got_a.delete();
    for (int i = 0; i < 4097; i++) begin
      step(1'b1, 1'b0);
      idle(7);
    end
    idle(4);
    check("saw_count", got_a.size(), 4097);
    check("saw_0", s12(got_a[0]), -2048);
    check("saw_1", s12(got_a[1]), -2047);
    check("saw_2", s12(got_a[2]), -2046);
    check("saw_4095", s12(got_a[4095]), 2047);
    check("saw_wrap", s12(got_a[4096]), -2048);

    // Sine in quarter-turn steps at half gain, then clamped over-unity gain.
    mode_a = 3'd1; ftw_a = 32'h4000_0000; amp_a = 13'd2048;
    sine_exp = '{0, 1023, 0, -1024};
    step(1'b0, 1'b1);
    idle(4);
    got_a.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    idle(5);
    for (int i = 0; i < 8; i++) check($sformatf("sine_half_%0d", i), s12(got_a[i]), sine_exp[i % 4]);
    amp_a = 13'd5000;
    sine_exp = '{0, 2047, 0, -2047};
    got_a.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    idle(5);
    for (int i = 0; i < 4; i++) check($sformatf("sine_clamp_%0d", i), s12(got_a[i]), sine_exp[i]);

    // Square duty over one full period, back-to-back strobes.
    mode_a = 3'd4; duty_a = 8'd64; ftw_a = 32'h0100_0000; amp_a = 13'd4096;
    step(1'b0, 1'b1);
    idle(4);
    got_a.delete();
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0);
    idle(5);
    cnt = 0;
    foreach (got_a[i]) if (s12(got_a[i]) == 2047) cnt++;
    check("sqr_high_count", cnt, 64);
    check("sqr_first", s12(got_a[0]), 2047);
    check("sqr_63", s12(got_a[63]), 2047);
    check("sqr_64", s12(got_a[64]), -2047);
    check("sqr_last", s12(got_a[255]), -2047);
    duty_a = 8'd0;
    got_a.delete();
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0);
    idle(5);
    cnt = 0;
    foreach (got_a[i]) if (s12(got_a[i]) == -2047) cnt++;
    check("sqr_duty0_count", cnt, 256);

    // phase_clr together with sample_en: this sample at phase 0, next at ftw.
    mode_a = 3'd2; ftw_a = 32'h1234_5678;
    step(1'b1, 1'b0);
    idle(5);
    ftw_a = 32'h4000_0000;
    got_a.delete();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    idle(5);
    check("clr_en_first", s12(got_a[0]), -2048);
    check("clr_en_second", s12(got_a[1]), -1024);

    // Three consecutive strobes give three pulses.
    snap = n_valid;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    idle(5);
    check("burst3_pulses", n_valid - snap, 3);

    // Reset one cycle after a strobe flushes it.
    snap = n_valid;
    step(1'b1, 1'b0);
    do_reset(1);
    idle(6);
    check("flush_pulses", n_valid - snap, 0);
    check("flush_dac_a", s12(dac_a), 0);
    check("flush_dac_b", s12(dac_b), 0);

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      mode_a = 3'($urandom_range(0, 7));  mode_b = 3'($urandom_range(0, 7));
      ftw_a = $urandom;                   ftw_b = $urandom;
      amp_a = 13'($urandom_range(0, 8191)); amp_b = 13'($urandom_range(0, 8191));
      offset_a = 12'($urandom);           offset_b = 12'($urandom);
      duty_a = 8'($urandom);              duty_b = 8'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 149) == 0) do_reset(1);
    end
    idle(6);
    check("drain_empty", exp_t_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
